pi_txn_queue: RTL and testbench

Pi-side transaction queue between the PI_A/PI_D register decode and the 68K bus-cycle FSM, all in the PI_CLK (~200 MHz) domain. It assembles address, data, direction and byte-lane information from Pi register writes into bus operations. It buffers those operations in a small FIFO and offers them one at a time to the bus FSM through a valid/start/done handshake. It captures read data and reports queue and error status back to the Pi.

---
 rtl/pi_txn_queue.sv | 181 ++++++++++++++++++
 tb/tb_pi_txn_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_txn_queue.sv
// Pi-side transaction queue: assembles Pi register writes into 68K bus ops, buffers
// them in a FIFO and hands them to the bus FSM. Optional stuck-op abort: PI_TXN_TIMEOUT_EN.
module pi_txn_queue #(
  parameter int DEPTH       = 4,
  parameter int CW          = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic          PI_CLK,
  input  logic          RESET_n,
  input  logic          wr_pulse,
  input  logic [1:0]    wr_reg,
  input  logic [15:0]   wr_data,
  input  logic          op_start,
  input  logic          op_done,
  input  logic [15:0]   bus_rd_data,
  output logic          op_valid,
  output logic [23:0]   op_addr,
  output logic [15:0]   op_data,
  output logic          op_rw,
  output logic          op_uds_n,
  output logic          op_lds_n,
  output logic [15:0]   rd_data,
  output logic          rd_data_valid,
  output logic          txn_busy,
  output logic [CW-1:0] q_count,
  output logic          q_full,
  output logic [2:0]    err_flags
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || (2 ** CW) <= DEPTH ||
      TIMEOUT_CYC < 1) begin : g_param_check
    $error("pi_txn_queue: illegal parameter set");
  end

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } op_t;

  op_t           mem_q [DEPTH];
  op_t           mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_flight_q, in_flight_d;
  logic [15:0]   hold_data_q, hold_data_d, hold_addr_q, hold_addr_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic [2:0]    err_q, err_d;

  op_t  head, new_op;
  logic empty, full, commit, is_byte, misalign, push, pop, start_ok, tmo_hit;

  assign head     = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign start_ok = op_start && !empty && !in_flight_q;
  assign commit   = wr_pulse && (wr_reg == 2'd2);
  assign is_byte  = wr_data[8];
  assign misalign = !is_byte && hold_addr_q[0];
  // The in-flight op still occupies the head slot, so a pop frees room for a same-cycle push.
  assign pop      = in_flight_q && (op_done || tmo_hit);
  assign push     = commit && !misalign && (!full || pop);

  always_comb begin
    new_op.addr  = {wr_data[7:0], hold_addr_q};
    new_op.data  = hold_data_q;
    new_op.rw    = wr_data[9];
    new_op.uds_n = is_byte ? hold_addr_q[0] : 1'b0;
    new_op.lds_n = is_byte ? !hold_addr_q[0] : 1'b0;
  end

`ifdef PI_TXN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = in_flight_q && (tmo_q == '0) && !op_done;

  always_comb begin
    tmo_d = tmo_q;
    if (start_ok) tmo_d = TW'(TIMEOUT_CYC - 1);
    else if (in_flight_q && tmo_q != '0) tmo_d = tmo_q - TW'(1);
  end

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    in_flight_d = in_flight_q;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    err_d       = err_q;

    if (wr_pulse && wr_reg == 2'd0) hold_data_d = wr_data;
    if (wr_pulse && wr_reg == 2'd1) hold_addr_d = wr_data;
    if (wr_pulse && wr_reg == 2'd3) err_d = err_d & ~wr_data[2:0];

    if (start_ok) in_flight_d = 1'b1;

    if (pop) begin
      in_flight_d = 1'b0;
      rd_ptr_d    = rd_ptr_q + PW'(1);
      if (head.rw) begin
        rd_data_d  = tmo_hit ? 16'hFFFF : bus_rd_data;
        rd_valid_d = 1'b1;
      end
      if (tmo_hit) err_d[2] = 1'b1;
    end

    if (commit && misalign)                err_d[1] = 1'b1;
    if (commit && !misalign && full && !pop) err_d[0] = 1'b1;

    if (push) begin
      mem_d[wr_ptr_q] = new_op;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      if (new_op.rw) rd_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_flight_q <= 1'b0;
      hold_data_q <= '0;
      hold_addr_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
    end
  end

  // Idle head outputs park at the bus-inactive values (read, both strobes off).
  assign op_valid      = !empty && !in_flight_q;
  assign op_addr       = empty ? 24'h0 : head.addr;
  assign op_data       = empty ? 16'h0 : head.data;
  assign op_rw         = empty ? 1'b1 : head.rw;
  assign op_uds_n      = empty ? 1'b1 : head.uds_n;
  assign op_lds_n      = empty ? 1'b1 : head.lds_n;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign txn_busy      = !empty || in_flight_q;
  assign q_count       = count_q;
  assign q_full        = full;
  assign err_flags     = err_q;

endmodule

// File: tb/tb_pi_txn_queue.sv
// Self-checking bench for pi_txn_queue: queue-level reference model compared every cycle,
// plus directed literal checks from the test plan.
module tb_pi_txn_queue;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_pulse = 1'b0;
  logic [1:0]  wr_reg = '0;
  logic [15:0] wr_data = '0;
  logic        op_start = 1'b0;
  logic        op_done = 1'b0;
  logic [15:0] bus_rd_data = '0;

  logic          op_valid, op_rw, op_uds_n, op_lds_n, rd_data_valid, txn_busy, q_full;
  logic [23:0]   op_addr;
  logic [15:0]   op_data, rd_data;
  logic [CW-1:0] q_count;
  logic [2:0]    err_flags;

  int checks = 0;
  int errors = 0;

  pi_txn_queue #(.DEPTH(DEPTH), .CW(CW), .TIMEOUT_CYC(TMO)) dut (
    .PI_CLK(clk), .RESET_n(rst_n), .wr_pulse(wr_pulse), .wr_reg(wr_reg), .wr_data(wr_data),
    .op_start(op_start), .op_done(op_done), .bus_rd_data(bus_rd_data),
    .op_valid(op_valid), .op_addr(op_addr), .op_data(op_data), .op_rw(op_rw),
    .op_uds_n(op_uds_n), .op_lds_n(op_lds_n), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .txn_busy(txn_busy), .q_count(q_count), .q_full(q_full), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of ops plus an in-flight flag.
  typedef struct {
    logic [23:0] a;
    logic [15:0] d;
    logic        rw, u, l;
  } mop_t;

  mop_t        mq[$];
  mop_t        mop;
  bit          m_if = 0, m_rv = 0, m_start, m_pop, m_tmo;
  logic [15:0] m_rd = '0, m_hd = '0, m_ha = '0;
  logic [2:0]  m_err = '0;
  int          m_cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_if = 0; m_rv = 0; m_rd = '0; m_hd = '0; m_ha = '0; m_err = '0; m_cyc = 0;
    end else begin
      m_start = op_start && !m_if && mq.size() > 0;
      m_tmo   = 0;
`ifdef PI_TXN_TIMEOUT_EN
      if (m_if) begin
        m_cyc++;
        if (!op_done && m_cyc == TMO) m_tmo = 1;
      end
`endif
      m_pop = m_if && (op_done || m_tmo);
      if (m_pop) begin
        if (mq[0].rw) begin
          m_rd = m_tmo ? 16'hFFFF : bus_rd_data;
          m_rv = 1;
        end
        if (m_tmo) m_err[2] = 1'b1;
        void'(mq.pop_front());
        m_if = 0;
      end
      if (wr_pulse) begin
        case (wr_reg)
          2'd0: m_hd = wr_data;
          2'd1: m_ha = wr_data;
          2'd2: begin
            mop.a  = {wr_data[7:0], m_ha};
            mop.d  = m_hd;
            mop.rw = wr_data[9];
            mop.u  = wr_data[8] ? m_ha[0] : 1'b0;
            mop.l  = wr_data[8] ? ~m_ha[0] : 1'b0;
            if (!wr_data[8] && m_ha[0]) m_err[1] = 1'b1;
            else if (mq.size() == DEPTH) m_err[0] = 1'b1;
            else begin
              mq.push_back(mop);
              if (mop.rw) m_rv = 0;
            end
          end
          default: m_err = m_err & ~wr_data[2:0];
        endcase
      end
      if (m_start) begin
        m_if  = 1;
        m_cyc = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("op_valid", op_valid, mq.size() > 0 && !m_if);
      chk("op_addr", op_addr, mq.size() > 0 ? mq[0].a : 24'h0);
      chk("op_data", op_data, mq.size() > 0 ? mq[0].d : 16'h0);
      chk("op_rw", op_rw, mq.size() > 0 ? mq[0].rw : 1'b1);
      chk("op_uds_n", op_uds_n, mq.size() > 0 ? mq[0].u : 1'b1);
      chk("op_lds_n", op_lds_n, mq.size() > 0 ? mq[0].l : 1'b1);
      chk("rd_data", rd_data, m_rd);
      chk("rd_data_valid", rd_data_valid, m_rv);
      chk("txn_busy", txn_busy, mq.size() > 0 || m_if);
      chk("q_count", q_count, mq.size());
      chk("q_full", q_full, mq.size() == DEPTH);
      chk("err_flags", err_flags, m_err);
    end
  end

  // Each task starts just after a rising edge and consumes exactly one cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] r, input logic [15:0] d);
    wr_pulse = 1'b1; wr_reg = r; wr_data = d;
    cyc();
    wr_pulse = 1'b0;
  endtask

  task automatic start_op();
    op_start = 1'b1;
    cyc();
    op_start = 1'b0;
  endtask

  task automatic done_op(input logic [15:0] d);
    op_done = 1'b1; bus_rd_data = d;
    cyc();
    op_done = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    chk("rst op_valid", op_valid, 0);
    chk("rst op_rw/uds/lds", {op_rw, op_uds_n, op_lds_n}, 3'b111);
    chk("rst q_count", q_count, 0);
    chk("rst err/rdv", {err_flags, rd_data_valid}, 4'b0000);

    // Word write commit
    wr(2'd0, 16'hBEEF); wr(2'd1, 16'h1234); wr(2'd2, 16'h0012);
    chk("ww op_valid", op_valid, 1);
    chk("ww op_addr", op_addr, 24'h121234);
    chk("ww op_data", op_data, 16'hBEEF);
    chk("ww rw/uds/lds", {op_rw, op_uds_n, op_lds_n}, 3'b000);
    start_op();
    chk("ww in flight valid", op_valid, 0);
    cyc();
    done_op(16'h0000);
    chk("ww popped", {txn_busy, q_count}, 4'b0000);

    // Two byte reads, odd then even address
    wr(2'd1, 16'h0001); wr(2'd2, 16'h0300); wr(2'd1, 16'h0002); wr(2'd2, 16'h0300);
    chk("br q_count", q_count, 2);
    chk("br1 rw/uds/lds", {op_rw, op_uds_n, op_lds_n}, 3'b110);
    start_op(); cyc(); cyc();
    done_op(16'h00A5);
    chk("br rd_data", rd_data, 16'h00A5);
    chk("br rd_data_valid", rd_data_valid, 1);
    chk("br2 addr", op_addr, 24'h000002);
    chk("br2 rw/uds/lds", {op_rw, op_uds_n, op_lds_n}, 3'b101);
    start_op();
    done_op(16'h5A00);
    chk("br2 rd_data", rd_data, 16'h5A00);

    // Misaligned word commit and W1C clear
    wr(2'd1, 16'h0003); wr(2'd2, 16'h0000);
    chk("mis q_count", q_count, 0);
    chk("mis err", err_flags, 3'b010);
    wr(2'd3, 16'h0002);
    chk("mis clr err", err_flags, 3'b000);

    // Overflow, then commit coincident with pop on a full queue
    for (int i = 0; i < 5; i++) begin
      wr(2'd1, 16'(i * 2));
      wr(2'd2, 16'h0001);
    end
    chk("ovf q_full", q_full, 1);
    chk("ovf q_count", q_count, 4);
    chk("ovf err", err_flags, 3'b001);
    start_op();
    wr(2'd1, 16'h0100);
    wr_pulse = 1'b1; wr_reg = 2'd2; wr_data = 16'h0001; op_done = 1'b1;
    cyc();
    wr_pulse = 1'b0; op_done = 1'b0;
    chk("pp q_count", q_count, 4);
    chk("pp err", err_flags, 3'b001);
    chk("pp head addr", op_addr, 24'h010002);

    // Async reset with an op in flight and 3 more queued
    start_op();
    #2 rst_n = 1'b0;
    #1;
    chk("arst op_valid", op_valid, 0);
    chk("arst q_count", q_count, 0);
    chk("arst txn_busy", txn_busy, 0);
    chk("arst err", err_flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Stuck read op
    wr(2'd1, 16'h0004); wr(2'd2, 16'h0200);
    start_op();
`ifdef PI_TXN_TIMEOUT_EN
    repeat (TMO - 1) cyc();
    chk("tmo pending", q_count, 1);
    cyc();
    chk("tmo q_count", q_count, 0);
    chk("tmo rd_data", rd_data, 16'hFFFF);
    chk("tmo rdv/err2", {rd_data_valid, err_flags[2]}, 2'b11);
    done_op(16'h1234);
    chk("tmo late done", rd_data, 16'hFFFF);
`else
    repeat (TMO * 2) cyc();
    chk("notmo still busy", {txn_busy, q_count}, 4'b1001);
    chk("notmo err", err_flags, 0);
    done_op(16'h1234);
    chk("notmo rd_data", rd_data, 16'h1234);
`endif
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
